// File: rtl/writeback_pkg.sv
// Shared types and helpers for the parametrised LC3 writeback stage.
// Source-select encoding, PSR bit positions and the condition-code function.
package writeback_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC  = 2'd2,
      WB_NPC = 2'd3
   } wb_sel_t;

   localparam int unsigned PSR_N = 2;
   localparam int unsigned PSR_Z = 1;
   localparam int unsigned PSR_P = 0;

   // Condition codes from the value's sign bit and an all-zero flag; exactly one bit set.
   function automatic logic [2:0] psr_of(input logic sign, input logic zero);
      logic [2:0] f;
      f        = '0;
      f[PSR_N] = sign;
      f[PSR_Z] = zero;
      f[PSR_P] = !sign && !zero;
      return f;
   endfunction

endpackage

// File: rtl/writeback_rf_core.sv
// NUM_REGS x DATA_W register file: one write port, two registered read ports.
// Collision behaviour selected by WRITEBACK_BYPASS_EN (write-first) or read-first when undefined.
module writeback_rf_core #(
   parameter  int unsigned DATA_W   = 16,
   parameter  int unsigned NUM_REGS = 8,
   localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);

   logic [DATA_W-1:0] r_mem [NUM_REGS];
   logic [DATA_W-1:0] r_rdata1;
   logic [DATA_W-1:0] r_rdata2;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   always_comb begin
      w_rd1 = r_mem[i_raddr1];
      w_rd2 = r_mem[i_raddr2];
`ifdef WRITEBACK_BYPASS_EN
      // Forward the value being written so a same-cycle read sees it.
      if (i_we && (i_waddr == i_raddr1)) w_rd1 = i_wdata;
      if (i_we && (i_waddr == i_raddr2)) w_rd2 = i_wdata;
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) r_mem[i] <= '0;
         r_rdata1 <= '0;
         r_rdata2 <= '0;
      end else begin
         if (i_we) r_mem[i_waddr] <= i_wdata;
         r_rdata1 <= w_rd1;
         r_rdata2 <= w_rd2;
      end
   end

   assign o_rdata1 = r_rdata1;
   assign o_rdata2 = r_rdata2;

endmodule

// File: rtl/writeback_regfile_p.sv
// LC3 writeback stage: source mux, N/Z/P condition codes and register-file instance.
// Optional write-first read bypass via WRITEBACK_BYPASS_EN.
module writeback_regfile_p
   import writeback_pkg::*;
#(
   parameter  int unsigned DATA_W   = 16,
   parameter  int unsigned NUM_REGS = 8,
   localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable_writeback,
   input  logic [1:0]        W_Control_in,
   input  logic [DATA_W-1:0] npc_in,
   input  logic [DATA_W-1:0] aluout,
   input  logic [DATA_W-1:0] pcout,
   input  logic [DATA_W-1:0] memout,
   input  logic [ADDR_W-1:0] dr,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [ADDR_W-1:0] sr2,
   output logic [DATA_W-1:0] VSR1,
   output logic [DATA_W-1:0] VSR2,
   output logic [2:0]        psr,
   output logic [DATA_W-1:0] wb_data
);

   logic [DATA_W-1:0] w_wb_data;
   logic [2:0]        r_psr;

   always_comb begin
      w_wb_data = aluout;
      unique case (wb_sel_t'(W_Control_in))
         WB_ALU:  w_wb_data = aluout;
         WB_MEM:  w_wb_data = memout;
         WB_PC:   w_wb_data = pcout;
         WB_NPC:  w_wb_data = npc_in;
         default: w_wb_data = aluout;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_psr <= 3'b000;
      end else if (enable_writeback) begin
         r_psr <= psr_of(w_wb_data[DATA_W-1], w_wb_data == '0);
      end
   end

   writeback_rf_core #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_rf_core (
      .i_clk    (clock),
      .i_rst_n  (reset),
      .i_we     (enable_writeback),
      .i_waddr  (dr),
      .i_wdata  (w_wb_data),
      .i_raddr1 (sr1),
      .i_raddr2 (sr2),
      .o_rdata1 (VSR1),
      .o_rdata2 (VSR2)
   );

   assign psr     = r_psr;
   assign wb_data = w_wb_data;

endmodule

// File: tb/tb_writeback_regfile_p.sv
// Self-checking bench for writeback_regfile_p: default 16x8 instance plus a 32x16 instance.
// Collision expectations follow WRITEBACK_BYPASS_EN when it is defined for the build.
module tb_writeback_regfile_p;

   logic        clock;
   logic        reset;

   logic        en;
   logic [1:0]  wsel;
   logic [15:0] npc, alu, pc, mem;
   logic [2:0]  dr, sr1, sr2;
   logic [15:0] vsr1, vsr2, wb;
   logic [2:0]  psr;

   logic        en2;
   logic [1:0]  wsel2;
   logic [31:0] npc2, alu2, pc2, mem2;
   logic [3:0]  dr2, sr1b, sr2b;
   logic [31:0] vsr1b, vsr2b, wb2;
   logic [2:0]  psr2;

   logic [15:0] m_reg  [8];
   logic [31:0] m_reg2 [16];
   logic [2:0]  m_psr, m_psr2;

   int n_cmp = 0;
   int n_err = 0;

   writeback_regfile_p u_dut (
      .clock            (clock),
      .reset            (reset),
      .enable_writeback (en),
      .W_Control_in     (wsel),
      .npc_in           (npc),
      .aluout           (alu),
      .pcout            (pc),
      .memout           (mem),
      .dr               (dr),
      .sr1              (sr1),
      .sr2              (sr2),
      .VSR1             (vsr1),
      .VSR2             (vsr2),
      .psr              (psr),
      .wb_data          (wb)
   );

   writeback_regfile_p #(
      .DATA_W   (32),
      .NUM_REGS (16)
   ) u_dut32 (
      .clock            (clock),
      .reset            (reset),
      .enable_writeback (en2),
      .W_Control_in     (wsel2),
      .npc_in           (npc2),
      .aluout           (alu2),
      .pcout            (pc2),
      .memout           (mem2),
      .dr               (dr2),
      .sr1              (sr1b),
      .sr2              (sr2b),
      .VSR1             (vsr1b),
      .VSR2             (vsr2b),
      .psr              (psr2),
      .wb_data          (wb2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference condition codes: negative, zero, or positive as a two's-complement number.
   function automatic logic [2:0] ref_psr(input logic [63:0] v, input int w);
      logic [63:0] mask;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      if (((v >> (w - 1)) & 64'd1) == 64'd1) return 3'b100;
      else if ((v & mask) == 64'd0)          return 3'b010;
      else                                   return 3'b001;
   endfunction

   function automatic logic bypass_on();
`ifdef WRITEBACK_BYPASS_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // One cycle on the 16-bit instance: v is placed on the source chosen by s.
   task automatic step(input logic e, input logic [1:0] s, input logic [15:0] v,
                       input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
      logic [15:0] x1, x2;
      @(negedge clock);
      en = e; wsel = s; dr = d; sr1 = a; sr2 = b;
      npc = 16'($urandom); alu = 16'($urandom); pc = 16'($urandom); mem = 16'($urandom);
      case (s)
         2'd0: alu = v;
         2'd1: mem = v;
         2'd2: pc  = v;
         default: npc = v;
      endcase
      #1;
      chk("wb_data", 64'(wb), 64'(v));
      x1 = (bypass_on() && e && d == a) ? v : m_reg[a];
      x2 = (bypass_on() && e && d == b) ? v : m_reg[b];
      if (e) begin
         m_reg[d] = v;
         m_psr    = ref_psr(64'(v), 16);
      end
      @(posedge clock);
      #1;
      chk("VSR1", 64'(vsr1), 64'(x1));
      chk("VSR2", 64'(vsr2), 64'(x2));
      chk("psr", 64'(psr), 64'(m_psr));
   endtask

   task automatic step32(input logic e, input logic [1:0] s, input logic [31:0] v,
                         input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
      logic [31:0] x1, x2;
      @(negedge clock);
      en2 = e; wsel2 = s; dr2 = d; sr1b = a; sr2b = b;
      npc2 = $urandom; alu2 = $urandom; pc2 = $urandom; mem2 = $urandom;
      case (s)
         2'd0: alu2 = v;
         2'd1: mem2 = v;
         2'd2: pc2  = v;
         default: npc2 = v;
      endcase
      #1;
      chk("wb_data32", 64'(wb2), 64'(v));
      x1 = (bypass_on() && e && d == a) ? v : m_reg2[a];
      x2 = (bypass_on() && e && d == b) ? v : m_reg2[b];
      if (e) begin
         m_reg2[d] = v;
         m_psr2    = ref_psr(64'(v), 32);
      end
      @(posedge clock);
      #1;
      chk("VSR1_32", 64'(vsr1b), 64'(x1));
      chk("VSR2_32", 64'(vsr2b), 64'(x2));
      chk("psr32", 64'(psr2), 64'(m_psr2));
   endtask

   initial begin
      logic [15:0] rv;
      logic [2:0]  rd, ra, rb;
      logic [31:0] rv2;
      logic [3:0]  rd2, ra2, rb2;

      reset = 1'b1;
      en = 0; wsel = 0; npc = 0; alu = 0; pc = 0; mem = 0; dr = 0; sr1 = 0; sr2 = 0;
      en2 = 0; wsel2 = 0; npc2 = 0; alu2 = 0; pc2 = 0; mem2 = 0; dr2 = 0; sr1b = 0; sr2b = 0;
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      for (int i = 0; i < 16; i++) m_reg2[i] = '0;
      m_psr = 3'b000; m_psr2 = 3'b000;
      #1 reset = 1'b0;
      #1;
      chk("rst_VSR1", 64'(vsr1), 64'd0);
      chk("rst_VSR2", 64'(vsr2), 64'd0);
      chk("rst_psr", 64'(psr), 64'd0);
      chk("rst_psr32", 64'(psr2), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Mid-run reset clears everything immediately.
      step(1, 2'd0, 16'h1234, 3'd3, 3'd0, 3'd0);
      step(0, 2'd0, 16'h0000, 3'd0, 3'd3, 3'd3);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("midrst_VSR1", 64'(vsr1), 64'd0);
      chk("midrst_VSR2", 64'(vsr2), 64'd0);
      chk("midrst_psr", 64'(psr), 64'd0);
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      for (int i = 0; i < 16; i++) m_reg2[i] = '0;
      m_psr = 3'b000; m_psr2 = 3'b000;
      @(negedge clock);
      reset = 1'b1;
      step(0, 2'd0, 16'h0000, 3'd0, 3'd3, 3'd3);

      // Source selection on reg1, including the link source.
      step(1, 2'd0, 16'h0005, 3'd1, 3'd0, 3'd0);
      step(1, 2'd1, 16'h8000, 3'd1, 3'd0, 3'd0);
      step(1, 2'd2, 16'h0000, 3'd1, 3'd0, 3'd0);
      step(1, 2'd3, 16'h3001, 3'd1, 3'd0, 3'd0);
      // Hold with writeback disabled, then read reg1 back.
      step(0, 2'd0, 16'hFFFF, 3'd1, 3'd1, 3'd1);
      // Read latency with both ports on the same index.
      step(1, 2'd0, 16'hABCD, 3'd2, 3'd0, 3'd0);
      step(0, 2'd0, 16'h0000, 3'd0, 3'd2, 3'd2);
      // Collision on reg4, then the follow-up read.
      step(1, 2'd0, 16'h0011, 3'd4, 3'd0, 3'd0);
      step(1, 2'd0, 16'h0022, 3'd4, 3'd4, 3'd0);
      step(0, 2'd0, 16'h0000, 3'd0, 3'd4, 3'd4);
      // Register 0 is writable.
      step(1, 2'd1, 16'h7FFF, 3'd0, 3'd0, 3'd0);
      step(0, 2'd0, 16'h0000, 3'd0, 3'd0, 3'd0);

      for (int k = 0; k < 300; k++) begin
         rd = 3'($urandom);
         ra = ($urandom_range(0, 2) == 0) ? rd : 3'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? rd : 3'($urandom);
         case ($urandom_range(0, 4))
            0:       rv = 16'h0000;
            1:       rv = 16'h8000 | 16'($urandom);
            default: rv = 16'($urandom);
         endcase
         step(1'($urandom), 2'($urandom), rv, rd, ra, rb);
      end

      // Wide instance: 32-bit data, 16 registers.
      step32(1, 2'd0, 32'h8000_0000, 4'd15, 4'd0, 4'd0);
      step32(0, 2'd0, 32'h0000_0000, 4'd0, 4'd0, 4'd15);
      step32(1, 2'd3, 32'h0000_0000, 4'd0, 4'd15, 4'd0);
      for (int k = 0; k < 60; k++) begin
         rd2 = 4'($urandom);
         ra2 = ($urandom_range(0, 2) == 0) ? rd2 : 4'($urandom);
         rb2 = ($urandom_range(0, 2) == 0) ? rd2 : 4'($urandom);
         rv2 = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         step32(1'($urandom), 2'($urandom), rv2, rd2, ra2, rb2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
